// File: rtl/sr_mul_sequencer.sv
// Iterative shift-add multiplier with its IDLE/BUSY/DONE sequencer.
// Stalls the core while running and presents the low WIDTH product bits for one cycle.
module sr_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (EARLY_EXIT && (mplier_q == '0)) begin
                    state_d = DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    // Early exit also fires on the step that consumes the top set bit,
                    // so a multiplier with MSB at bit k finishes at T+k+2.
                    if ((cnt_q == CNT_LAST) || (EARLY_EXIT && ((mplier_q >> 1) == '0))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall        = ((state_q == IDLE) && start) || (state_q == BUSY);
    assign busy         = (state_q == BUSY);
    assign result_valid = (state_q == DONE);
    assign result       = acc_q;

endmodule

// File: tb/tb_sr_mul_sequencer.sv
// Bench for sr_mul_sequencer: one instance without and one with early exit,
// each checked cycle by cycle against a latency/product model.
module tb_sr_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s        [2];
    logic [31:0] a_s            [2];
    logic [31:0] b_s            [2];
    logic        stall_s        [2];
    logic        busy_s         [2];
    logic [31:0] result_s       [2];
    logic        result_valid_s [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .src_a(a_s[0]), .src_b(b_s[0]),
        .stall(stall_s[0]), .busy(busy_s[0]), .result(result_s[0]),
        .result_valid(result_valid_s[0])
    );

    sr_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .src_a(a_s[1]), .src_b(b_s[1]),
        .stall(stall_s[1]), .busy(busy_s[1]), .result(result_s[1]),
        .result_valid(result_valid_s[1])
    );

    // Cycles from the start cycle to the result_valid cycle.
    function automatic int exp_lat(input int sel, input logic [31:0] b);
        if (sel == 0) return 33;
        if (b == 32'd0) return 2;
        for (int i = 31; i >= 0; i--) begin
            if (b[i]) return i + 2;
        end
        return 2;
    endfunction

    function automatic logic [31:0] exp_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // One operation from its start cycle (c=0) through a few idle cycles after DONE.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit perturb, input string name);
        int          lat;
        logic [31:0] expv;
        lat  = exp_lat(sel, b);
        expv = exp_prod(a, b);
        @(negedge clk);
        start_s[sel] = 1'b1;
        a_s[sel]     = a;
        b_s[sel]     = b;
        for (int c = 0; c <= lat + 3; c++) begin
            #1;
            checks++;
            if (stall_s[sel] !== (c < lat)) begin
                errors++;
                $display("FAIL %s[ee%0d] stall cycle %0d: got %b want %b", name, sel, c, stall_s[sel], (c < lat));
            end
            checks++;
            if (busy_s[sel] !== (c >= 1 && c < lat)) begin
                errors++;
                $display("FAIL %s[ee%0d] busy cycle %0d: got %b want %b", name, sel, c, busy_s[sel], (c >= 1 && c < lat));
            end
            checks++;
            if (result_valid_s[sel] !== (c == lat)) begin
                errors++;
                $display("FAIL %s[ee%0d] result_valid cycle %0d: got %b want %b", name, sel, c, result_valid_s[sel], (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (result_s[sel] !== expv) begin
                    errors++;
                    $display("FAIL %s[ee%0d] result: got %h want %h", name, sel, result_s[sel], expv);
                end
            end
            @(negedge clk);
            start_s[sel] = hold && (c + 1 <= lat);
            if (perturb && c == 3) begin
                a_s[sel] = $urandom;
                b_s[sel] = $urandom;
            end
        end
        start_s[sel] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (stall_s[s] !== 1'b0 || busy_s[s] !== 1'b0 || result_valid_s[s] !== 1'b0 || result_s[s] !== 32'd0) begin
                errors++;
                $display("FAIL reset[ee%0d]: stall=%b busy=%b rv=%b result=%h want 0 0 0 0",
                         s, stall_s[s], busy_s[s], result_valid_s[s], result_s[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (stall_s[s] !== 1'b0 || busy_s[s] !== 1'b0 || result_valid_s[s] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle[ee%0d]: stall=%b busy=%b rv=%b want 0 0 0",
                         s, stall_s[s], busy_s[s], result_valid_s[s]);
            end
        end
    endtask

    task automatic test_basic();
        run_op(0, 32'd3, 32'd5, 1'b0, 1'b0, "basic_3x5");
        run_op(1, 32'd3, 32'd5, 1'b0, 1'b0, "basic_3x5");
    endtask

    task automatic test_carry();
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "carry_ffff");
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "carry_ffff");
    endtask

    task automatic test_early_exit();
        run_op(1, 32'h1234, 32'd1, 1'b0, 1'b0, "early_b1");
        run_op(1, 32'h1234, 32'd0, 1'b0, 1'b0, "early_b0");
        run_op(1, 32'hDEAD_BEEF, 32'h8000_0000, 1'b0, 1'b0, "early_msb31");
        run_op(0, 32'h1234, 32'd0, 1'b0, 1'b0, "noearly_b0");
    endtask

    task automatic test_hold_start();
        run_op(0, 32'h0001_2345, 32'h0000_0F0F, 1'b1, 1'b1, "hold_perturb");
        run_op(1, 32'h0001_2345, 32'h0000_0F0F, 1'b1, 1'b1, "hold_perturb");
    endtask

    task automatic test_back_to_back(input int sel);
        int lat1, lat2, t2;
        lat1 = exp_lat(sel, 32'd6);
        lat2 = exp_lat(sel, 32'd9);
        t2   = lat1 + 1;
        @(negedge clk);
        start_s[sel] = 1'b1;
        a_s[sel]     = 32'd7;
        b_s[sel]     = 32'd6;
        for (int c = 0; c <= t2 + lat2 + 3; c++) begin
            #1;
            checks++;
            if (stall_s[sel] !== ((c < lat1) || (c >= t2 && c < t2 + lat2))) begin
                errors++;
                $display("FAIL b2b[ee%0d] stall cycle %0d: got %b", sel, c, stall_s[sel]);
            end
            checks++;
            if (result_valid_s[sel] !== ((c == lat1) || (c == t2 + lat2))) begin
                errors++;
                $display("FAIL b2b[ee%0d] result_valid cycle %0d: got %b", sel, c, result_valid_s[sel]);
            end
            if (c == lat1) begin
                checks++;
                if (result_s[sel] !== 32'd42) begin
                    errors++;
                    $display("FAIL b2b[ee%0d] first result: got %0d want 42", sel, result_s[sel]);
                end
            end
            if (c == t2 + lat2) begin
                checks++;
                if (result_s[sel] !== 32'd81) begin
                    errors++;
                    $display("FAIL b2b[ee%0d] second result: got %0d want 81", sel, result_s[sel]);
                end
            end
            @(negedge clk);
            if (c == 0) begin
                a_s[sel] = 32'd9;
                b_s[sel] = 32'd9;
            end
            start_s[sel] = (c + 1 <= t2);
        end
        start_s[sel] = 1'b0;
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0]     = 32'h0BAD_F00D;
        b_s[0]     = 32'hFFFF_FFFF;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        #1;
        checks++;
        if (busy_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort busy_before: got %b want 1", busy_s[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || result_valid_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort idle: stall=%b busy=%b rv=%b want 0 0 0", stall_s[0], busy_s[0], result_valid_s[0]);
        end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (result_valid_s[0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort no_pulse: got %0d pulses want 0", pulses);
        end
        run_op(0, 32'd11, 32'd13, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(0, a, b, 1'b0, 1'b0, "rand");
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_op(1, a, b, 1'b0, (i % 2) == 1, "rand");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            a_s[s]     = 32'd0;
            b_s[s]     = 32'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_carry();
        test_early_exit();
        test_hold_start();
        test_back_to_back(0);
        test_back_to_back(1);
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
